// File: rtl/modulo_updown_counter.sv
// modulo_updown_counter
//
// Up/down counter over the range 0..MAX_VAL. At a boundary it either wraps
// or saturates. A counter register, a one-cycle terminal-count pulse and a
// sticky wrap flag are kept.
//
// Parameters
//   WIDTH     counter width in bits
//   RESET_VAL count value loaded by reset
//   MAX_VAL   top of the count range (range is 0..MAX_VAL)
//   PRESCALE  enable divider ratio; only used when MODCNT_PRESCALE_EN is defined
//
// Optional feature
//   MODCNT_PRESCALE_EN  when defined, an internal prescaler allows one step
//                       every PRESCALE enabled cycles
//
// Ports
//   clk       clock; all state updates on its rising edge
//   reset     synchronous reset, active low (0 = reset)
//   en        count enable
//   up_dn     direction select (1 = up, 0 = down)
//   load      synchronous parallel load strobe (beats en)
//   load_val  value to load; values above MAX_VAL are clamped to MAX_VAL
//   sat_mode  boundary behaviour (1 = saturate, 0 = wrap)
//   clr_ovf   clears ovf (a coincident wrap wins)
//   count     registered count
//   tc        one-cycle pulse after a step taken from a boundary
//   ovf       sticky flag, set on every wrap
module modulo_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 4,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  // Parameter legality is checked at elaboration time.
  if (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("modulo_updown_counter: MAX_VAL does not fit in WIDTH bits");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("modulo_updown_counter: RESET_VAL exceeds MAX_VAL");
  end

  // Loaded values above the range are pinned to the ceiling.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
    return (val > MAX_V) ? MAX_V : val;
  endfunction

  // Next count for one step. At a boundary in the counting direction the
  // count either stays put (saturate) or jumps to the opposite end (wrap).
  function automatic logic [WIDTH-1:0] step_count(
    input logic [WIDTH-1:0] cur,
    input logic             dir_up,
    input logic             sat,
    input logic             bound
  );
    logic [WIDTH-1:0] nxt;
    if (!bound)      nxt = dir_up ? cur + WIDTH'(1) : cur - WIDTH'(1);
    else if (sat)    nxt = cur;
    else             nxt = dir_up ? '0 : MAX_V;
    return nxt;
  endfunction

  logic tick;

`ifdef MODCNT_PRESCALE_EN
  if (PRESCALE < 2) begin : g_bad_psc
    $error("modulo_updown_counter: PRESCALE must be at least 2");
  end

  localparam int PSC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;

  // Tick on the last phase of each PRESCALE-long group of enabled cycles.
  assign tick = (psc == PSC_LAST);

  // Prescaler advances only on enabled, non-load cycles; en=0 freezes the phase.
  always_ff @(posedge clk) begin
    if (!reset || load) begin
      psc <= '0;
    end else if (en) begin
      psc <= tick ? '0 : psc + PSC_W'(1);
    end
  end
`else
  // Without the prescaler every enabled cycle steps; the ratio has no effect.
  if (PRESCALE < 0) begin : g_psc_unused
  end
  assign tick = 1'b1;
`endif

  logic             step;
  logic             at_bound;
  logic             wrap;
  logic [WIDTH-1:0] count_step;

  always_comb begin
    step       = en && !load && tick;
    at_bound   = up_dn ? (count == MAX_V) : (count == '0);
    wrap       = step && at_bound && !sat_mode;
    count_step = step_count(count, up_dn, sat_mode, at_bound);
  end

  // Single register stage: reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= RST_V;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load) begin
        count <= clamp_load(load_val);
        tc    <= 1'b0;
      end else if (step) begin
        count <= count_step;
        tc    <= at_bound;
      end else begin
        tc    <= 1'b0;
      end
      // Set wins over a coincident clear.
      ovf <= wrap || (ovf && !clr_ovf);
    end
  end

endmodule

// File: tb/tb_modulo_updown_counter.sv
module tb_modulo_updown_counter;

  localparam int WIDTH     = 8;
  localparam int RESET_VAL = 4;
  localparam int MAX_VAL   = 9;

  logic             clk;
  logic             reset;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat_mode;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modulo_updown_counter #(
    .WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .MAX_VAL(MAX_VAL), .PRESCALE(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .count(count), .tc(tc), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] lv;
    logic       sat;
    logic       clr;
    int         e_count;
    logic       e_tc;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input int v, input logic s, input logic c,
                     input int ec, input logic et, input logic eo);
    vec_t x;
    x.rst_n = r; x.en = e; x.up = u; x.ld = l; x.lv = 8'(v);
    x.sat = s; x.clr = c; x.e_count = ec; x.e_tc = et; x.e_ovf = eo;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic u, input logic l,
                       input logic [7:0] v, input logic s, input logic c);
    reset = r; en = e; up_dn = u; load = l; load_val = v; sat_mode = s; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model state, computed with plain modular arithmetic.
  int   m_count;
  logic m_tc;
  logic m_ovf;

  task automatic model_step(input logic r, input logic e, input logic u, input logic l,
                            input int v, input logic s, input logic c);
    bit bound;
    if (!r) begin
      m_count = RESET_VAL; m_tc = 0; m_ovf = 0;
    end else if (l) begin
      m_count = (v > MAX_VAL) ? MAX_VAL : v;
      m_tc    = 0;
      m_ovf   = m_ovf && !c;
    end else if (e) begin
      bound = u ? (m_count == MAX_VAL) : (m_count == 0);
      m_ovf = (bound && !s) || (m_ovf && !c);
      m_tc  = bound;
      if (!(bound && s))
        m_count = u ? (m_count + 1) % (MAX_VAL + 1) : (m_count + MAX_VAL) % (MAX_VAL + 1);
    end else begin
      m_tc  = 0;
      m_ovf = m_ovf && !c;
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    sat_mode = 1'b0; clr_ovf = 1'b0;

    //   rst en up ld  lv  sat clr   count tc ovf
    // Reset for two cycles, then count up through a wrap.
    add(0, 1, 1, 0,   0, 0, 0,      4, 0, 0);
    add(0, 1, 1, 0,   0, 0, 0,      4, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0,      5, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0,      6, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0,      7, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0,      8, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0,      9, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0,      0, 1, 1);
    add(1, 0, 1, 0,   0, 0, 0,      0, 0, 1);
    // Load 0 (with clear), then saturate downward three times.
    add(1, 0, 0, 1,   0, 1, 1,      0, 0, 0);
    add(1, 1, 0, 0,   0, 1, 0,      0, 1, 0);
    add(1, 1, 0, 0,   0, 1, 0,      0, 1, 0);
    add(1, 1, 0, 0,   0, 1, 0,      0, 1, 0);
    // Out-of-range load clamps, en ignored; then wrap up.
    add(1, 1, 1, 1, 200, 0, 0,      9, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0,      0, 1, 1);
    // Clear coinciding with a wrap loses; clear next cycle wins.
    add(1, 0, 1, 1,   9, 0, 0,      9, 0, 1);
    add(1, 1, 1, 0,   0, 0, 1,      0, 1, 1);
    add(1, 0, 1, 0,   0, 0, 1,      0, 0, 0);
    // Reset with load during a wrap.
    add(1, 0, 1, 1,   9, 0, 0,      9, 0, 0);
    add(0, 1, 1, 1,   3, 0, 1,      4, 0, 0);
    // Downward wrap, then a normal down step.
    add(1, 0, 0, 1,   0, 0, 0,      0, 0, 0);
    add(1, 1, 0, 0,   0, 0, 0,      9, 1, 1);
    add(1, 1, 0, 0,   0, 0, 0,      8, 0, 1);
    // Saturate up at the ceiling keeps ovf and pulses tc.
    add(1, 1, 1, 1,   9, 1, 0,      9, 0, 1);
    add(1, 1, 1, 0,   0, 1, 0,      9, 1, 1);
    add(1, 1, 1, 0,   0, 1, 1,      9, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv,
            vecs[i].sat, vecs[i].clr);
      chk("tbl_count", i, 32'(count), 32'(vecs[i].e_count));
      chk("tbl_tc",    i, 32'(tc),    32'(vecs[i].e_tc));
      chk("tbl_ovf",   i, 32'(ovf),   32'(vecs[i].e_ovf));
    end

    // Randomized run against the reference model, started from a reset.
    m_count = 0; m_tc = 0; m_ovf = 0;
    model_step(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 8'd0, 0, 0);
    chk("rnd_rst_count", 0, 32'(count), 32'(m_count));
    for (int i = 1; i <= 400; i++) begin
      logic r, e, u, l, s, c;
      logic [7:0] v;
      r = ($urandom_range(0, 29) != 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1);
      l = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, MAX_VAL));
      s = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 5) == 0);
      model_step(r, e, u, l, int'(v), s, c);
      apply(r, e, u, l, v, s, c);
      chk("rnd_count", i, 32'(count), 32'(m_count));
      chk("rnd_tc",    i, 32'(tc),    32'(m_tc));
      chk("rnd_ovf",   i, 32'(ovf),   32'(m_ovf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
